uart_tx_async: RTL and testbench

Asynchronous serial transmitter paired with the CoreUARTapb receive path. It has a one-entry transmit holding register and shifts each frame out LSB-first on `tx`, timed by the shared 16x baud enable. Frame format matches the receiver: 7 or 8 data bits, optional odd/even parity, 1 or 2 stop bits. It sits between the APB register block (which writes the holding register) and the `tx` pad.

---
 rtl/uart_tx_async.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_async.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_async.sv
// uart_tx_async
// Asynchronous serial transmitter with a one-entry transmit holding register.
// Frames are shifted out LSB-first, with each bit lasting 16 ticks of the
// shared 16x baud enable. The frame is a start bit, 7 or 8 data bits, an
// optional odd/even parity bit and STOP_BITS stop bits.
//
// Ports
//   clk         system clock; all logic is on the rising edge
//   reset       synchronous, active-high reset
//   baud_clock  16x oversample enable, one clk wide per tick
//   bit8        1 = 8 data bits, 0 = 7 data bits (tx_data[7] is not sent)
//   parity_en   1 = append a parity bit after the data bits
//   odd_n_even  1 = odd parity, 0 = even parity
//   tx_data     byte to transmit
//   write_tx    single-cycle strobe that loads tx_data into the holding register
//   txrdy       holding register empty; a write is accepted
//   tx          serial line, idle high, registered
//   tx_busy     a frame is in progress
//   tx_done     one-clk pulse at the end of the last stop bit
//
// state  | meaning
// IDLE   | line high; loads the next frame when the holding register is full
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | STOP_BITS stop bits (line high)
module uart_tx_async #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic [7:0] tx_data,
  input  logic       write_tx,
  output logic       txrdy,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  hold_q;
  logic [7:0]  shift_q;
  logic        txrdy_q;
  logic        bit8_q;
  logic        par_en_q;
  logic        odd_q;
  logic        par_q;
  logic [3:0]  tick_q;
  logic [3:0]  tick_d;
  logic [2:0]  bitcnt_q;
  logic [2:0]  bitcnt_d;
  logic        stopcnt_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;

  logic        bit_end;
  logic        last_data;
  logic        last_stop;

  assign tick_d    = tick_q + 4'd1;
  assign bitcnt_d  = bitcnt_q + 3'd1;
  assign bit_end   = baud_clock && (tick_q == 4'd15);
  assign last_data = (bitcnt_q == (bit8_q ? 3'd7 : 3'd6));
  // With one stop bit the first stop period is already the last one.
  assign last_stop = (STOP_BITS < 2) || stopcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= 8'h00;
      shift_q   <= 8'h00;
      txrdy_q   <= 1'b1;
      bit8_q    <= 1'b1;
      par_en_q  <= 1'b0;
      odd_q     <= 1'b0;
      par_q     <= 1'b0;
      tick_q    <= 4'd0;
      bitcnt_q  <= 3'd0;
      stopcnt_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A write while the register is full is silently dropped.
      if (write_tx && txrdy_q) begin
        hold_q  <= tx_data;
        txrdy_q <= 1'b0;
      end

      if ((state_q != IDLE) && baud_clock) begin
        tick_q <= tick_d;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!txrdy_q) begin
            shift_q  <= hold_q;
            bit8_q   <= bit8;
            par_en_q <= parity_en;
            odd_q    <= odd_n_even;
            par_q    <= 1'b0;
            txrdy_q  <= 1'b1;
            tick_q   <= 4'd0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bitcnt_q <= 3'd0;
            tx_q     <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            par_q   <= par_q ^ shift_q[0];
            if (last_data) begin
              if (par_en_q) begin
                // par_q has not yet absorbed the bit that is ending now.
                tx_q    <= par_q ^ shift_q[0] ^ odd_q;
                state_q <= PARITY;
              end else begin
                stopcnt_q <= 1'b0;
                tx_q      <= 1'b1;
                state_q   <= STOP;
              end
            end else begin
              bitcnt_q <= bitcnt_d;
              tx_q     <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            stopcnt_q <= 1'b0;
            tx_q      <= 1'b1;
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              stopcnt_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign txrdy   = txrdy_q;
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Testbench for uart_tx_async. Two instances (one and two stop bits) share the
// line configuration and baud enable; each has its own write strobe. A frame
// level reference model predicts the line, txrdy, tx_busy and tx_done on every
// cycle from the byte, the configuration latched at load and the number of
// baud ticks elapsed since the load.
module tb_uart_tx_async;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_clock = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] wr = 2'b00;
  logic [1:0] txrdy;
  logic [1:0] tx;
  logic [1:0] tx_busy;
  logic [1:0] tx_done;

  always #5 clk = ~clk;

  uart_tx_async #(.STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .tx_data(tx_data),
    .write_tx(wr[0]), .txrdy(txrdy[0]), .tx(tx[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0])
  );

  uart_tx_async #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .tx_data(tx_data),
    .write_tx(wr[1]), .txrdy(txrdy[1]), .tx(tx[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_ticks(input int n, input int p, input int s);
    return 16 * (1 + n + p + s);
  endfunction

  // Baud enable generator: fixed divider or random pulses.
  int baud_div  = 1;
  bit baud_rand = 1'b0;
  int bcnt      = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (baud_rand) begin
        baud_clock = ($urandom_range(0, 1) == 1);
      end else begin
        bcnt++;
        if (bcnt >= baud_div) begin
          bcnt = 0;
          baud_clock = 1'b1;
        end else begin
          baud_clock = 1'b0;
        end
      end
    end
  end

  // Inputs as seen by the DUT at the most recent rising edge.
  logic       s_reset = 1'b1;
  logic       s_baud  = 1'b0;
  logic       s_bit8  = 1'b1;
  logic       s_par   = 1'b0;
  logic       s_odd   = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic [1:0] s_wr    = 2'b00;
  always @(posedge clk) begin
    s_reset <= reset;
    s_baud  <= baud_clock;
    s_bit8  <= bit8;
    s_par   <= parity_en;
    s_odd   <= odd_n_even;
    s_data  <= tx_data;
    s_wr    <= wr;
  end

  // Reference model state per instance.
  bit         m_rdy   [2] = '{1'b1, 1'b1};
  bit         m_busy  [2] = '{1'b0, 1'b0};
  bit         m_done  [2] = '{1'b0, 1'b0};
  logic [7:0] m_hold  [2];
  int         m_ticks [2] = '{0, 0};
  int         m_nbits [2] = '{1, 1};
  bit         m_bits  [2][12];

  // Observations gathered from the DUT outputs.
  bit prev_busy [2] = '{1'b0, 1'b0};
  int obs_cnt   [2] = '{0, 0};
  int obs_len   [2] = '{0, 0};
  int done_cnt  [2] = '{0, 0};

  task automatic build_frame(input int i);
    int n;
    int ones;
    int k;
    n    = s_bit8 ? 8 : 7;
    ones = 0;
    k    = 0;
    m_bits[i][k++] = 1'b0;
    for (int b = 0; b < n; b++) begin
      m_bits[i][k++] = m_hold[i][b];
      if (m_hold[i][b]) ones++;
    end
    if (s_par) m_bits[i][k++] = ((ones % 2) == 1) ^ s_odd;
    for (int s = 0; s <= i; s++) m_bits[i][k++] = 1'b1;
    m_nbits[i] = k;
  endtask

  task automatic model_step(input int i);
    bit acc;
    m_done[i] = 1'b0;
    if (s_reset) begin
      m_rdy[i]   = 1'b1;
      m_busy[i]  = 1'b0;
      m_ticks[i] = 0;
      m_hold[i]  = 8'h00;
    end else begin
      acc = s_wr[i] && m_rdy[i];
      if (m_busy[i]) begin
        if (s_baud) begin
          m_ticks[i]++;
          if (m_ticks[i] == 16 * m_nbits[i]) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end else if (!m_rdy[i]) begin
        build_frame(i);
        m_busy[i]  = 1'b1;
        m_ticks[i] = 0;
        m_rdy[i]   = 1'b1;
      end
      if (acc) begin
        m_hold[i] = s_data;
        m_rdy[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    bit exp_line;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        model_step(i);
        exp_line = m_busy[i] ? m_bits[i][m_ticks[i] / 16] : 1'b1;
        check($sformatf("tx%0d", i),      {31'd0, tx[i]},      {31'd0, exp_line});
        check($sformatf("txrdy%0d", i),   {31'd0, txrdy[i]},   {31'd0, m_rdy[i]});
        check($sformatf("tx_busy%0d", i), {31'd0, tx_busy[i]}, {31'd0, m_busy[i]});
        check($sformatf("tx_done%0d", i), {31'd0, tx_done[i]}, {31'd0, m_done[i]});
        if (prev_busy[i] && s_baud) obs_cnt[i]++;
        if (tx_busy[i] && !prev_busy[i]) obs_cnt[i] = 0;
        if (tx_done[i] === 1'b1) begin
          obs_len[i] = obs_cnt[i];
          done_cnt[i]++;
        end
        prev_busy[i] = (tx_busy[i] === 1'b1);
      end
    end
  end

  // Called at a falling edge; the strobe is sampled at the next rising edge.
  task automatic wr_byte(input logic [1:0] mask, input logic [7:0] d);
    tx_data = d;
    wr      = mask;
    @(negedge clk);
    wr      = 2'b00;
  endtask

  task automatic wait_idle(input int i);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b1;
    while (!(tx_busy[i] === 1'b0 && txrdy[i] === 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 20000) begin
        ok = 1'b0;
        break;
      end
    end
    check($sformatf("idle_wait%0d", i), {31'd0, ok}, 32'd1);
  endtask

  task automatic set_cfg(input bit b8, input bit pe, input bit od);
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = od;
  endtask

  initial begin
    int d0;
    int n;
    bit seen;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx",    {30'd0, tx},      32'd3);
    check("rst_txrdy", {30'd0, txrdy},   32'd3);
    check("rst_busy",  {30'd0, tx_busy}, 32'd0);
    check("rst_done",  {30'd0, tx_done}, 32'd0);

    // 8N1 / 8N2, baud every cycle, 0xA5.
    set_cfg(1'b1, 1'b0, 1'b0);
    baud_div = 1;
    wr_byte(2'b11, 8'hA5);
    wait_idle(0);
    wait_idle(1);
    check("len_8n1", obs_len[0], frame_ticks(8, 0, 1));
    check("len_8n2", obs_len[1], frame_ticks(8, 0, 2));

    // 7E1 / 7E2, baud every 4th cycle, 0xC3.
    set_cfg(1'b0, 1'b1, 1'b0);
    baud_div = 4;
    wr_byte(2'b11, 8'hC3);
    wait_idle(0);
    wait_idle(1);
    check("len_7e1", obs_len[0], frame_ticks(7, 1, 1));
    check("len_7e2", obs_len[1], frame_ticks(7, 1, 2));

    // 8O2 on the two-stop instance, 0xFF.
    set_cfg(1'b1, 1'b1, 1'b1);
    baud_div = 2;
    wr_byte(2'b10, 8'hFF);
    wait_idle(1);
    check("len_8o2", obs_len[1], frame_ticks(8, 1, 2));

    // Back-to-back frames; a third write while full is dropped.
    set_cfg(1'b1, 1'b0, 1'b0);
    baud_div = 1;
    d0 = done_cnt[0];
    wr_byte(2'b01, 8'h55);
    n = 0;
    while (txrdy[0] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    wr_byte(2'b01, 8'hAA);
    wr_byte(2'b01, 8'h33);
    n    = 0;
    seen = 1'b0;
    while (n < 1000) begin
      if (tx_done[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("b2b_gap_tx",   {31'd0, tx[0]},      32'd0);
    check("b2b_gap_busy", {31'd0, tx_busy[0]}, 32'd1);
    wait_idle(0);
    check("b2b_frames", done_cnt[0] - d0, 32'd2);

    // Reset during data bit 3, with a second byte waiting.
    wr_byte(2'b01, 8'h3C);
    repeat (4) @(negedge clk);
    wr_byte(2'b01, 8'h81);
    repeat (66) @(negedge clk);
    d0 = done_cnt[0];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx",    {31'd0, tx[0]},      32'd1);
    check("abort_busy",  {31'd0, tx_busy[0]}, 32'd0);
    check("abort_txrdy", {31'd0, txrdy[0]},   32'd1);
    repeat (300) @(negedge clk);
    check("abort_no_done", done_cnt[0] - d0, 32'd0);
    check("abort_idle_tx", {31'd0, tx[0]},   32'd1);

    // Configuration change mid-frame only affects the next frame.
    set_cfg(1'b1, 1'b0, 1'b0);
    wr_byte(2'b01, 8'h0F);
    repeat (40) @(negedge clk);
    set_cfg(1'b0, 1'b1, 1'b1);
    wait_idle(0);
    check("cfg_hold_len", obs_len[0], frame_ticks(8, 0, 1));
    set_cfg(1'b0, 1'b0, 1'b0);
    wr_byte(2'b01, 8'h0F);
    wait_idle(0);
    check("cfg_new_len", obs_len[0], frame_ticks(7, 0, 1));

    // Randomized traffic, configuration and baud spacing.
    for (int it = 0; it < 40; it++) begin
      set_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
      baud_rand = ($urandom_range(0, 3) == 0);
      baud_div  = $urandom_range(1, 3);
      wr_byte(2'($urandom_range(1, 3)), 8'($urandom));
      repeat ($urandom_range(0, 300)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) wr_byte(2'($urandom_range(1, 3)), 8'($urandom));
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    wait_idle(0);
    wait_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
